// File: rtl/k052109_vram_sched.sv
// k052109_vram_sched: time-slot scheduler for the tile generator's three
// 8-bit VRAM chips sharing one RA bus. Even slots fetch tile words for the
// FIX / A / B / SCROLL requesters, odd slots serve the CPU port.
// Optional build macro K052109_VBLANK_CPU_EN: while VBLK is high at the
// start of a slot, even slots are handed to the CPU as well.
//
// All pin outputs are registered from the counter values of the cycle being
// entered, so each output reflects the slot/cycle it belongs to. Read data
// is captured on the edge that enters the last cycle of a slot.
module k052109_vram_sched #(
  parameter int SLOT_CYC = 4,
  parameter int SLOTS    = 8
) (
  input  logic        M24,
  input  logic        RES,
  input  logic        CHAR_SYNC,
  input  logic        VBLK,
  input  logic [51:0] FADDR,
  output logic [23:0] FDATA,
  output logic [3:0]  FVALID,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_SEL,
  input  logic [12:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_RDATA,
  output logic [12:0] RA,
  output logic [2:0]  ROE_n,
  output logic [2:0]  RWE_n,
  output logic [7:0]  VD_O,
  output logic        VD_OE,
  input  logic [23:0] VD_I
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

  // Active-low strobe mask for one RAM; select 3 addresses no RAM.
  function automatic logic [2:0] ram_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    ram_mask = 3'b110;
      2'd1:    ram_mask = 3'b101;
      2'd2:    ram_mask = 3'b011;
      default: ram_mask = 3'b111;
    endcase
  endfunction

  // Byte lane of the selected RAM; an unmapped select reads as all ones.
  function automatic logic [7:0] sel_byte(input logic [23:0] d, input logic [1:0] sel);
    case (sel)
      2'd0:    sel_byte = d[7:0];
      2'd1:    sel_byte = d[15:8];
      2'd2:    sel_byte = d[23:16];
      default: sel_byte = 8'hFF;
    endcase
  endfunction

  logic [CW-1:0] cyc, cyc_nx;
  logic [SW-1:0] slot, slot_nx;
  logic          is_cpu, is_cpu_nx;
  logic          pend, pend_nx;
  logic          p_we;
  logic [1:0]    p_sel;
  logic [12:0]   p_addr;
  logic [7:0]    p_wdata;

  logic          vblank_cpu, take, busy, last, abort;
  logic          a_we;
  logic [1:0]    a_sel, fidx;
  logic [12:0]   a_addr;
  logic [7:0]    a_wdata;

  logic [12:0]   ra_nx;
  logic [2:0]    roe_nx, rwe_nx;
  logic [7:0]    vdo_nx, rdata_nx;
  logic          vdoe_nx, ack_nx;
  logic [23:0]   fdata_nx;
  logic [3:0]    fvalid_nx;

`ifdef K052109_VBLANK_CPU_EN
  assign vblank_cpu = VBLK;
`else
  logic unused_vblk;
  assign vblank_cpu  = 1'b0;
  assign unused_vblk = VBLK;
`endif

  // Next slot/cycle, CPU latch decision and next pin values for that cycle.
  always_comb begin
    if (CHAR_SYNC) begin
      cyc_nx  = '0;
      slot_nx = '0;
    end else if (cyc == CYC_LAST) begin
      cyc_nx  = '0;
      slot_nx = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
    end else begin
      cyc_nx  = cyc + CW'(1);
      slot_nx = slot;
    end

    is_cpu_nx = (cyc_nx == '0) ? (slot_nx[0] | vblank_cpu) : is_cpu;
    take      = (cyc_nx == '0) && is_cpu_nx && !pend && CPU_REQ && !CPU_ACK;
    busy      = take | pend;
    last      = (cyc_nx == CYC_LAST);
    abort     = CHAR_SYNC && (cyc != CYC_LAST);
    fidx      = 2'(slot_nx >> 1);

    a_we    = take ? CPU_WE    : p_we;
    a_sel   = take ? CPU_SEL   : p_sel;
    a_addr  = take ? CPU_ADDR  : p_addr;
    a_wdata = take ? CPU_WDATA : p_wdata;

    ra_nx     = RA;
    roe_nx    = 3'b111;
    rwe_nx    = 3'b111;
    vdo_nx    = VD_O;
    vdoe_nx   = 1'b0;
    fdata_nx  = FDATA;
    fvalid_nx = 4'b0000;
    ack_nx    = 1'b0;
    rdata_nx  = CPU_RDATA;
    pend_nx   = busy;

    if (!is_cpu_nx) begin
      // Address follows the field while the strobe is active, so the slot
      // entered straight out of reset fetches as well.
      if (!last) begin
        ra_nx  = FADDR[13*fidx +: 13];
        roe_nx = 3'b000;
      end else begin
        fdata_nx  = VD_I;
        fvalid_nx = 4'b0001 << fidx;
      end
    end else if (busy) begin
      ra_nx = a_addr;
      if (a_we) begin
        vdo_nx  = a_wdata;
        vdoe_nx = 1'b1;
        if ((cyc_nx != '0) && !last)
          rwe_nx = ram_mask(a_sel);
        if (last) begin
          ack_nx  = 1'b1;
          pend_nx = 1'b0;
        end
      end else begin
        if (!last) begin
          roe_nx = ram_mask(a_sel);
        end else begin
          rdata_nx = sel_byte(VD_I, a_sel);
          ack_nx   = 1'b1;
          pend_nx  = 1'b0;
        end
      end
    end

    // A mid-slot realign kills the running strobes; a latched CPU access
    // stays pending and reruns in the next CPU slot.
    if (abort) begin
      roe_nx  = 3'b111;
      rwe_nx  = 3'b111;
      vdoe_nx = 1'b0;
    end
  end

  // Control state and registered pins, cleared asynchronously.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      cyc       <= '0;
      slot      <= '0;
      is_cpu    <= 1'b0;
      pend      <= 1'b0;
      RA        <= '0;
      ROE_n     <= 3'b111;
      RWE_n     <= 3'b111;
      VD_O      <= '0;
      VD_OE     <= 1'b0;
      FDATA     <= '0;
      FVALID    <= '0;
      CPU_ACK   <= 1'b0;
      CPU_RDATA <= '0;
    end else begin
      cyc       <= cyc_nx;
      slot      <= slot_nx;
      is_cpu    <= is_cpu_nx;
      pend      <= pend_nx;
      RA        <= ra_nx;
      ROE_n     <= roe_nx;
      RWE_n     <= rwe_nx;
      VD_O      <= vdo_nx;
      VD_OE     <= vdoe_nx;
      FDATA     <= fdata_nx;
      FVALID    <= fvalid_nx;
      CPU_ACK   <= ack_nx;
      CPU_RDATA <= rdata_nx;
    end
  end

  // Captured CPU access fields; only meaningful while pend is set.
  always_ff @(posedge M24) begin
    if (take) begin
      p_we    <= CPU_WE;
      p_sel   <= CPU_SEL;
      p_addr  <= CPU_ADDR;
      p_wdata <= CPU_WDATA;
    end
  end

endmodule

// File: tb/tb_k052109_vram_sched.sv
// Bench for k052109_vram_sched: directed vectors, expected fetch and CPU
// completions queued by the stimulus and popped by a monitor on each strobe.
module tb_k052109_vram_sched;

  logic        M24 = 1'b0;
  logic        RES = 1'b0;
  logic        CHAR_SYNC = 1'b0;
  logic        VBLK = 1'b0;
  logic [51:0] FADDR = '0;
  logic [23:0] FDATA;
  logic [3:0]  FVALID;
  logic        CPU_REQ = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [1:0]  CPU_SEL = 2'd0;
  logic [12:0] CPU_ADDR = '0;
  logic [7:0]  CPU_WDATA = '0;
  logic        CPU_ACK;
  logic [7:0]  CPU_RDATA;
  logic [12:0] RA;
  logic [2:0]  ROE_n;
  logic [2:0]  RWE_n;
  logic [7:0]  VD_O;
  logic        VD_OE;
  logic [23:0] VD_I = '0;

  k052109_vram_sched dut (
    .M24(M24), .RES(RES), .CHAR_SYNC(CHAR_SYNC), .VBLK(VBLK),
    .FADDR(FADDR), .FDATA(FDATA), .FVALID(FVALID),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_SEL(CPU_SEL),
    .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_ACK(CPU_ACK),
    .CPU_RDATA(CPU_RDATA), .RA(RA), .ROE_n(ROE_n), .RWE_n(RWE_n),
    .VD_O(VD_O), .VD_OE(VD_OE), .VD_I(VD_I)
  );

  always #5 M24 = ~M24;

  // Cycle number since reset release, as seen at the falling edge.
  int tcyc;
  always @(posedge M24 or negedge RES) begin
    if (!RES) tcyc <= 0;
    else      tcyc <= tcyc + 1;
  end

  typedef struct { int cyc; logic [3:0] v; logic [23:0] d; } fexp_t;
  typedef struct { int cyc; logic [7:0] rd; } cexp_t;
  fexp_t fq[$];
  cexp_t cq[$];
  fexp_t fe;
  cexp_t ce;
  bit    fmon = 1'b0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tcyc);
  endtask

  task automatic push_f(input int c, input logic [3:0] v, input logic [23:0] d);
    fq.push_back('{cyc: c, v: v, d: d});
  endtask

  task automatic push_c(input int c, input logic [7:0] rd);
    cq.push_back('{cyc: c, rd: rd});
  endtask

  task automatic wait_cyc(input int k);
    while (tcyc < k) @(negedge M24);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_RA"},     32'(RA), 32'h0);
    chk({tag, "_ROE_n"},  32'(ROE_n), 32'h7);
    chk({tag, "_RWE_n"},  32'(RWE_n), 32'h7);
    chk({tag, "_VD_O"},   32'(VD_O), 32'h0);
    chk({tag, "_VD_OE"},  32'(VD_OE), 32'h0);
    chk({tag, "_FDATA"},  32'(FDATA), 32'h0);
    chk({tag, "_FVALID"}, 32'(FVALID), 32'h0);
    chk({tag, "_ACK"},    32'(CPU_ACK), 32'h0);
    chk({tag, "_RDATA"},  32'(CPU_RDATA), 32'h0);
  endtask

  task automatic do_reset();
    CHAR_SYNC = 1'b0;
    CPU_REQ   = 1'b0;
    @(negedge M24);
    RES = 1'b0;
    repeat (2) @(negedge M24);
    chk_reset_vals("reset");
    RES = 1'b1;
  endtask

  task automatic cpu_req(input logic we, input logic [1:0] sel,
                         input logic [12:0] addr, input logic [7:0] wd);
    CPU_WE    = we;
    CPU_SEL   = sel;
    CPU_ADDR  = addr;
    CPU_WDATA = wd;
    CPU_REQ   = 1'b1;
  endtask

  // Scoreboard monitor: every fetch strobe or CPU ack pops one expectation.
  always @(negedge M24) begin
    if (RES) begin
      if (fmon && FVALID != 4'b0000) begin
        if (fq.size() == 0) begin
          n_chk++;
          $display("FAIL fvalid_unexpected: got %b at cycle %0d, expected none", FVALID, tcyc);
        end else begin
          fe = fq.pop_front();
          chk("fvalid", 32'(FVALID), 32'(fe.v));
          chk("fdata", 32'(FDATA), 32'(fe.d));
          chk("fvalid_cycle", 32'(tcyc), 32'(fe.cyc));
        end
      end
      if (CPU_ACK) begin
        if (cq.size() == 0) begin
          n_chk++;
          $display("FAIL ack_unexpected: got ack at cycle %0d, expected none", tcyc);
        end else begin
          ce = cq.pop_front();
          chk("cpu_rdata", 32'(CPU_RDATA), 32'(ce.rd));
          chk("ack_cycle", 32'(tcyc), 32'(ce.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fetch rotation straight out of reset; VBLK must not matter by default.
    FADDR = {13'h1003, 13'h1002, 13'h1001, 13'h1000};
    VD_I  = 24'hA5B6C7;
`ifndef K052109_VBLANK_CPU_EN
    VBLK = 1'b1;
`endif
    do_reset();
    push_f(3,  4'b0001, 24'hA5B6C7);
    push_f(11, 4'b0010, 24'hA5B6C7);
    push_f(19, 4'b0100, 24'hA5B6C7);
    push_f(27, 4'b1000, 24'hA5B6C7);
    fmon = 1'b1;
    wait_cyc(1);
    chk("fix_ROE_low", 32'(ROE_n), 32'h0);
    chk("fix_RA", 32'(RA), 32'h1000);
    wait_cyc(3);
    chk("fix_RA_at_valid", 32'(RA), 32'h1000);
    chk("fix_ROE_release", 32'(ROE_n), 32'h7);
    wait_cyc(9);
    chk("a_RA", 32'(RA), 32'h1001);
    wait_cyc(29);
    fmon = 1'b0;
    chk("fetch_queue_empty", 32'(fq.size()), 32'h0);

    // Asynchronous reset in the middle of a fetch slot.
    wait_cyc(33);
    #2;
    RES = 1'b0;
    #1;
    chk("async_ROE_n", 32'(ROE_n), 32'h7);
    chk("async_RA", 32'(RA), 32'h0);
    chk("async_FDATA", 32'(FDATA), 32'h0);
    @(negedge M24);
    VBLK = 1'b0;

    // CPU write to RAM1 issued in slot 0, served in slot 1.
    do_reset();
    wait_cyc(1);
    cpu_req(1'b1, 2'd1, 13'h0ABC, 8'h5A);
    push_c(7, 8'h00);
    wait_cyc(4);
    chk("wr_RA", 32'(RA), 32'h0ABC);
    chk("wr_VD_O", 32'(VD_O), 32'h5A);
    chk("wr_VD_OE", 32'(VD_OE), 32'h1);
    chk("wr_RWE_cyc0", 32'(RWE_n), 32'h7);
    wait_cyc(5);
    chk("wr_RWE_cyc1", 32'(RWE_n), 32'h5);
    wait_cyc(6);
    chk("wr_RWE_cyc2", 32'(RWE_n), 32'h5);
    wait_cyc(7);
    chk("wr_RWE_cyc3", 32'(RWE_n), 32'h7);
    CPU_REQ = 1'b0;
    wait_cyc(8);
    chk("wr_VD_OE_drop", 32'(VD_OE), 32'h0);

    // CPU read of RAM2, then a read with no RAM selected.
    VD_I = 24'h3C0000;
    wait_cyc(9);
    cpu_req(1'b0, 2'd2, 13'h0123, 8'h00);
    push_c(15, 8'h3C);
    wait_cyc(12);
    chk("rd_ROE_n", 32'(ROE_n), 32'h3);
    chk("rd_RA", 32'(RA), 32'h0123);
    wait_cyc(15);
    CPU_REQ = 1'b0;
    wait_cyc(17);
    cpu_req(1'b0, 2'd3, 13'h0042, 8'h00);
    push_c(23, 8'hFF);
    wait_cyc(21);
    chk("sel3_ROE_n", 32'(ROE_n), 32'h7);
    chk("sel3_RWE_n", 32'(RWE_n), 32'h7);
    wait_cyc(23);
    CPU_REQ = 1'b0;
    wait_cyc(26);
    chk("cpu_queue_empty_rw", 32'(cq.size()), 32'h0);

    // CHAR_SYNC aborting a write, then aborting the layer A fetch.
    VD_I = 24'hA5B6C7;
    do_reset();
    wait_cyc(1);
    cpu_req(1'b1, 2'd0, 13'h0111, 8'h99);
    push_c(13, 8'h00);
    wait_cyc(5);
    chk("ab_RWE_before", 32'(RWE_n), 32'h6);
    CHAR_SYNC = 1'b1;
    wait_cyc(6);
    CHAR_SYNC = 1'b0;
    chk("ab_RWE_after", 32'(RWE_n), 32'h7);
    chk("ab_VD_OE_after", 32'(VD_OE), 32'h0);
    chk("ab_ROE_after", 32'(ROE_n), 32'h7);
    push_f(9,  4'b0001, 24'hA5B6C7);
    push_f(19, 4'b0001, 24'hA5B6C7);
    fmon = 1'b1;
    wait_cyc(7);
    chk("ab_fix_ROE", 32'(ROE_n), 32'h0);
    wait_cyc(10);
    chk("retry_RA", 32'(RA), 32'h0111);
    chk("retry_VD_O", 32'(VD_O), 32'h99);
    chk("retry_VD_OE", 32'(VD_OE), 32'h1);
    wait_cyc(11);
    chk("retry_RWE", 32'(RWE_n), 32'h6);
    wait_cyc(13);
    CPU_REQ = 1'b0;
    wait_cyc(15);
    CHAR_SYNC = 1'b1;
    wait_cyc(16);
    CHAR_SYNC = 1'b0;
    wait_cyc(20);
    fmon = 1'b0;
    chk("abort_fetch_queue_empty", 32'(fq.size()), 32'h0);
    chk("abort_cpu_queue_empty", 32'(cq.size()), 32'h0);

`ifdef K052109_VBLANK_CPU_EN
    // During blank the even slot 2 takes the CPU read; no fetch strobes.
    do_reset();
    VBLK = 1'b1;
    wait_cyc(4);
    fmon = 1'b1;
    wait_cyc(5);
    cpu_req(1'b0, 2'd0, 13'h0555, 8'h00);
    push_c(11, 8'hC7);
    wait_cyc(8);
    chk("vb_ROE_n", 32'(ROE_n), 32'h6);
    chk("vb_RA", 32'(RA), 32'h0555);
    wait_cyc(11);
    CPU_REQ = 1'b0;
    wait_cyc(16);
    fmon = 1'b0;
    VBLK = 1'b0;
    chk("vb_cpu_queue_empty", 32'(cq.size()), 32'h0);
`endif

    repeat (2) @(negedge M24);
    chk("final_fetch_queue_empty", 32'(fq.size()), 32'h0);
    chk("final_cpu_queue_empty", 32'(cq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
